alu_control_muldiv: RTL and testbench
=====================================

Name: alu_control_muldiv

Overview:
Parametrised successor to the CPU's ALU control decoder. Decodes Aluop/Funct for the full MIPS R-type ALU set, including shifts, xor, nor and sltu. Adds an iterative multiply/divide engine with HI/LO registers and a stall handshake to the PC/register-write logic. Sits beside the main ALU in the datapath. Feeds Alucontrol to the ALU and HiLoOut to the writeback mux.

Parameters:
WIDTH, 32, datapath width of SrcA/SrcB/HI/LO (>=4).
CW, 6, width of the iteration counter; must satisfy 2^CW > WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Valid  input  1  instruction in this cycle is real (not a bubble)
Aluop  input  2  from main control: 00 lw/sw, 01 beq, 10 R-type, 11 reserved
Funct  input  6  instruction[5:0]
SrcA  input  WIDTH  rs operand
SrcB  input  WIDTH  rt operand
Alucontrol  output  4  ALU operation select
Illegal  output  1  undecodable op with Valid=1
Stall  output  1  hold PC and suppress register write this cycle
HiLoSel  output  1  writeback takes HiLoOut (mfhi/mflo)
HiLoOut  output  WIDTH  HI (mfhi) or LO (mflo), else 0
Busy  output  1  mul/div engine iterating

Behaviour:
- Decode is combinational, with no x outputs.
- Aluop 00 -> 0010. Aluop 01 -> 0110. Aluop 11 -> 1111 with Illegal=Valid.
- Aluop 10 Funct mapping:
  - add 100000 / addu 100001 -> 0010
  - sub 100010 / subu 100011 -> 0110
  - and 100100 -> 0000; or 100101 -> 0001; xor 100110 -> 0011; nor 100111 -> 1100
  - slt 101010 -> 0111; sltu 101011 -> 1000
  - sll 000000 -> 1001; srl 000010 -> 1010; sra 000011 -> 1011
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011 -> 1111, Illegal=0
  - any other Funct -> 1111, Illegal=Valid
- HiLoSel=1 only for mfhi/mflo with Aluop=10.
- Engine states: IDLE, MUL, DIV.
  - Issue: Valid & ~Stall & mult/div funct in IDLE.
  - At the issue edge: latch |SrcA|, |SrcB| (signed ops) or raw values (unsigned); latch result sign; count<=WIDTH; state<=MUL or DIV.
  - MUL uses shift-add, one bit per cycle. DIV uses restoring division, one bit per cycle.
  - Each busy edge decrements count. On the edge where count==1: write HI/LO with sign correction, then go to IDLE. Busy is therefore high for exactly WIDTH cycles after the issue edge.
  - Sign correction for mult: product negated if the operand signs differ. HI=upper WIDTH bits, LO=lower WIDTH bits.
  - Sign correction for div: LO=quotient negated if signs differ; HI=remainder carrying the dividend's sign.
- Divide by zero, all variants: LO=all ones, HI=SrcA. Takes the full WIDTH cycles; no exception.
- Signed overflow (-2^(WIDTH-1) / -1): LO=-2^(WIDTH-1), HI=0.
- Stall = Valid & Busy & (Funct is any mf/mt/mult/div code) & Aluop==10. All other instructions proceed while Busy.
- mthi/mtlo in IDLE: HI/LO<=SrcA at the edge; visible to mfhi/mflo the following cycle.
- HiLoOut reflects the registered HI/LO and is combinational on Funct.
- Valid=0: no issue, no HI/LO write, Stall=0, Illegal=0. Alucontrol still decodes.
- Reset (any time, including mid-operation): state=IDLE, Busy=0, count=0, HI=LO=0, internal operands=0. A pending result is discarded. Stall=0 while reset is asserted.

Test Plan:
- Decode sweep: Aluop=10 over every listed Funct -> table values. Funct=111111, Valid=1 -> Alucontrol=1111, Illegal=1. Aluop=00/01 -> 0010/0110. Aluop=11 -> Illegal=1.
- mult SrcA=-3, SrcB=7 (WIDTH=32) -> Busy for 32 cycles. Back-to-back mflo stalls cycles 1-32. Cycle 33: HiLoOut=0xFFFFFFEB with mflo, 0xFFFFFFFF with mfhi.
- multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. div -7/2 -> LO=-3 (0xFFFFFFFD), HI=-1 (0xFFFFFFFF).
- divu 100/0 -> LO=0xFFFFFFFF, HI=100. div 0x80000000/-1 -> LO=0x80000000, HI=0.
- Independent add issued during Busy -> Stall=0, Alucontrol=0010. mthi 0x1234 in IDLE, then mfhi next cycle -> HiLoOut=0x1234.
- Assert reset at cycle 10 of a div -> Busy=0, HI=LO=0 immediately. mflo after release -> 0, Stall=0.

Source files
------------

// File: rtl/alu_control_muldiv.sv
// ALU control decoder for the MIPS R-type ALU set, plus an iterative
// multiply/divide engine with HI/LO registers and a stall handshake.
module alu_control_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic [1:0]       Aluop,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [3:0]       Alucontrol,
    output logic             Illegal,
    output logic             Stall,
    output logic             HiLoSel,
    output logic [WIDTH-1:0] HiLoOut,
    output logic             Busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;      // {upper, lower}: {acc, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]     r_b;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0]     r_araw;   // raw dividend, returned in HI on divide by zero
    logic                 r_negq, r_negr, r_dz;
    logic [WIDTH-1:0]     r_hi, r_lo;

    logic                 w_rtype, w_known, w_f_hilo, w_f_muldiv, w_f_signed;
    logic                 w_f_mfhi, w_f_mflo, w_f_mthi, w_f_mtlo;
    logic                 w_issue, w_mt_ok, w_last;
    logic                 w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_a_abs, w_b_abs;
    logic [WIDTH:0]       w_mul_sum, w_div_sh;
    logic [WIDTH-1:0]     w_div_diff, w_div_r;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_mul_p, w_div_p, w_mul_res;
    logic [WIDTH-1:0]     w_q_res, w_r_res;

    assign w_rtype    = (Aluop == 2'b10);
    assign w_f_hilo   = (Funct[5:2] == 4'b0100);
    assign w_f_muldiv = (Funct[5:2] == 4'b0110);
    assign w_f_signed = ~Funct[0];
    assign w_f_mfhi   = (Funct == 6'b010000);
    assign w_f_mthi   = (Funct == 6'b010001);
    assign w_f_mflo   = (Funct == 6'b010010);
    assign w_f_mtlo   = (Funct == 6'b010011);

    assign Busy    = (r_state != S_IDLE);
    assign Stall   = Valid & Busy & w_rtype & (w_f_hilo | w_f_muldiv);
    assign HiLoSel = w_rtype & (w_f_mfhi | w_f_mflo);
    assign w_issue = Valid & ~Stall & w_rtype & w_f_muldiv & (r_state == S_IDLE);
    assign w_mt_ok = Valid & ~Stall & w_rtype & (w_f_mthi | w_f_mtlo) & (r_state == S_IDLE);
    assign w_last  = (r_cnt == CW'(1));

    // Combinational ALU-control decode; unknown ops fall back to 1111
    always_comb begin
        Alucontrol = 4'b1111;
        w_known    = 1'b1;
        case (Aluop)
            2'b00: Alucontrol = 4'b0010;
            2'b01: Alucontrol = 4'b0110;
            2'b10: begin
                case (Funct)
                    6'b100000, 6'b100001: Alucontrol = 4'b0010;
                    6'b100010, 6'b100011: Alucontrol = 4'b0110;
                    6'b100100:            Alucontrol = 4'b0000;
                    6'b100101:            Alucontrol = 4'b0001;
                    6'b100110:            Alucontrol = 4'b0011;
                    6'b100111:            Alucontrol = 4'b1100;
                    6'b101010:            Alucontrol = 4'b0111;
                    6'b101011:            Alucontrol = 4'b1000;
                    6'b000000:            Alucontrol = 4'b1001;
                    6'b000010:            Alucontrol = 4'b1010;
                    6'b000011:            Alucontrol = 4'b1011;
                    default:              w_known = w_f_hilo | w_f_muldiv;
                endcase
            end
            default: w_known = 1'b0;
        endcase
        Illegal = Valid & ~w_known;
    end

    // HI/LO read port for mfhi/mflo, zero otherwise
    always_comb begin
        HiLoOut = '0;
        if (w_rtype && w_f_mfhi) HiLoOut = r_hi;
        if (w_rtype && w_f_mflo) HiLoOut = r_lo;
    end

    // Operand magnitudes and one-bit-per-cycle shift-add / restoring-divide steps
    always_comb begin
        w_a_neg    = w_f_signed & SrcA[WIDTH-1];
        w_b_neg    = w_f_signed & SrcB[WIDTH-1];
        w_a_abs    = w_a_neg ? -SrcA : SrcA;
        w_b_abs    = w_b_neg ? -SrcB : SrcB;
        w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : '0);
        w_mul_p    = {w_mul_sum, r_p[WIDTH-1:1]};
        w_div_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
        w_div_ge   = (w_div_sh >= {1'b0, r_b});
        w_div_diff = w_div_sh[WIDTH-1:0] - r_b;
        w_div_r    = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
        w_div_p    = {w_div_r, r_p[WIDTH-2:0], w_div_ge};
        w_mul_res  = r_negq ? -w_mul_p : w_mul_p;
        w_q_res    = r_negq ? -w_div_p[WIDTH-1:0] : w_div_p[WIDTH-1:0];
        w_r_res    = r_negr ? -w_div_p[2*WIDTH-1:WIDTH] : w_div_p[2*WIDTH-1:WIDTH];
    end

    // Engine state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Engine next-state: issue from IDLE, return on the final iteration
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_issue) w_state_nxt = Funct[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration, and HI/LO writeback (result or mthi/mtlo)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_p    <= '0;
            r_b    <= '0;
            r_araw <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_dz   <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (w_issue) begin
            r_cnt  <= CW'(WIDTH);
            r_p    <= {{WIDTH{1'b0}}, w_a_abs};
            r_b    <= w_b_abs;
            r_araw <= SrcA;
            r_negq <= w_a_neg ^ w_b_neg;
            r_negr <= w_a_neg;
            r_dz   <= (SrcB == '0);
        end else if (Busy) begin
            r_cnt <= r_cnt - CW'(1);
            r_p   <= (r_state == S_MUL) ? w_mul_p : w_div_p;
            if (w_last) begin
                if (r_state == S_MUL) begin
                    r_hi <= w_mul_res[2*WIDTH-1:WIDTH];
                    r_lo <= w_mul_res[WIDTH-1:0];
                end else if (r_dz) begin
                    // sign correction must not touch the divide-by-zero result
                    r_hi <= r_araw;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_r_res;
                    r_lo <= w_q_res;
                end
            end
        end else if (w_mt_ok) begin
            if (w_f_mthi) r_hi <= SrcA;
            else          r_lo <= SrcA;
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Self-checking bench for alu_control_muldiv: decode table, directed
// mul/div corner sequences, and randomized mul/div against an arithmetic model.
module tb_alu_control_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, Valid;
    logic [1:0]    Aluop;
    logic [5:0]    Funct;
    logic [W-1:0]  SrcA, SrcB;
    logic [3:0]    Alucontrol;
    logic          Illegal, Stall, HiLoSel, Busy;
    logic [W-1:0]  HiLoOut;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001,
                           F_MFLO = 6'b010010, F_MTLO = 6'b010011,
                           F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU = 6'b011011,
                           F_ADD  = 6'b100000;

    alu_control_muldiv #(.WIDTH(W), .CW(6)) dut (
        .clk(clk), .reset(reset), .Valid(Valid), .Aluop(Aluop), .Funct(Funct),
        .SrcA(SrcA), .SrcB(SrcB), .Alucontrol(Alucontrol), .Illegal(Illegal),
        .Stall(Stall), .HiLoSel(HiLoSel), .HiLoOut(HiLoOut), .Busy(Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [3:0] alu;
        logic       ill;
        logic       sel;
    } dvec_t;

    dvec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the architectural definition
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            F_MULT:  begin sp = 64'(sa) * 64'(sb); return sp; end
            F_MULTU: return {32'd0, a} * {32'd0, b};
            F_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    // Issue one mul/div op, hold mflo during busy, then read HI/LO
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output int n, output int nostall);
        Valid = 1'b1; Aluop = 2'b10; Funct = f; SrcA = a; SrcB = b;
        tick();
        Funct = F_MFLO; SrcA = '0; SrcB = '0;
        n = 0; nostall = 0;
        while (Busy && n < 100) begin
            if (!Stall) nostall++;
            tick();
            n++;
        end
        Funct = F_MFHI; #1 hi = HiLoOut;
        Funct = F_MFLO; #1 lo = HiLoOut;
    endtask

    initial begin
        logic [31:0] hi, lo;
        logic [63:0] e;
        int n, ns;

        tbl.push_back('{2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b100001, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b100011, 4'b0110, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b100110, 4'b0011, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b100111, 4'b1100, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b101011, 4'b1000, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b000000, 4'b1001, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b000010, 4'b1010, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b000011, 4'b1011, 1'b0, 1'b0});
        tbl.push_back('{2'b10, F_MFHI,    4'b1111, 1'b0, 1'b1});
        tbl.push_back('{2'b10, F_MTHI,    4'b1111, 1'b0, 1'b0});
        tbl.push_back('{2'b10, F_MFLO,    4'b1111, 1'b0, 1'b1});
        tbl.push_back('{2'b10, F_MTLO,    4'b1111, 1'b0, 1'b0});
        tbl.push_back('{2'b10, F_MULT,    4'b1111, 1'b0, 1'b0});
        tbl.push_back('{2'b10, F_MULTU,   4'b1111, 1'b0, 1'b0});
        tbl.push_back('{2'b10, F_DIV,     4'b1111, 1'b0, 1'b0});
        tbl.push_back('{2'b10, F_DIVU,    4'b1111, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 6'b111111, 4'b1111, 1'b1, 1'b0});
        tbl.push_back('{2'b10, 6'b000001, 4'b1111, 1'b1, 1'b0});
        tbl.push_back('{2'b00, 6'b010010, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{2'b01, 6'b100100, 4'b0110, 1'b0, 1'b0});
        tbl.push_back('{2'b11, 6'b100000, 4'b1111, 1'b1, 1'b0});

        // Reset state; decode sweep runs under reset so no op can issue
        reset = 1'b1; Valid = 1'b1; Aluop = 2'b10; Funct = F_MFLO; SrcA = '0; SrcB = '0;
        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_stall", 64'(Stall), 64'd0);
        chk("rst_lo", 64'(HiLoOut), 64'd0);
        foreach (tbl[i]) begin
            Aluop = tbl[i].aluop; Funct = tbl[i].funct; Valid = 1'b1;
            #1;
            chk($sformatf("dec_alu[%0d]", i), 64'(Alucontrol), 64'(tbl[i].alu));
            chk($sformatf("dec_ill[%0d]", i), 64'(Illegal), 64'(tbl[i].ill));
            chk($sformatf("dec_sel[%0d]", i), 64'(HiLoSel), 64'(tbl[i].sel));
            Valid = 1'b0;
            #1;
            chk($sformatf("dec_ill_nv[%0d]", i), 64'(Illegal), 64'd0);
        end
        tick();
        reset = 1'b0;
        tick();

        // Valid=0 must not issue
        Valid = 1'b0; Aluop = 2'b10; Funct = F_MULT; SrcA = 32'd5; SrcB = 32'd5;
        tick();
        chk("novalid_busy", 64'(Busy), 64'd0);

        // mult -3*7 with back-to-back stalled mflo
        Valid = 1'b1; Funct = F_MULT; SrcA = 32'hFFFF_FFFD; SrcB = 32'd7;
        #1 chk("mult_issue_stall", 64'(Stall), 64'd0);
        tick();
        Funct = F_MFLO;
        n = 0; ns = 0;
        for (int c = 1; c <= 32; c++) begin
            if (!(Busy && Stall)) ns++;
            tick();
        end
        chk("mult_stall_cycles", 64'(ns), 64'd0);
        chk("mult_done_busy", 64'(Busy), 64'd0);
        chk("mult_done_stall", 64'(Stall), 64'd0);
        chk("mult_lo", 64'(HiLoOut), 64'hFFFF_FFEB);
        Funct = F_MFHI;
        #1 chk("mult_hi", 64'(HiLoOut), 64'hFFFF_FFFF);

        // Directed corners
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, n, ns);
        chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, hi, lo, n, ns);
        chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(F_DIVU, 32'd100, 32'd0, hi, lo, n, ns);
        chk("divu_by0", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        chk("divu_by0_len", 64'(n), 64'd32);
        run_op(F_DIV, 32'hFFFF_FFF0, 32'd0, hi, lo, n, ns);
        chk("div_neg_by0", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, n, ns);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        // Independent add during Busy proceeds
        Valid = 1'b1; Funct = F_DIVU; SrcA = 32'd1000; SrcB = 32'd7;
        tick();
        Funct = F_ADD;
        repeat (5) tick();
        chk("add_busy", 64'(Busy), 64'd1);
        chk("add_stall", 64'(Stall), 64'd0);
        chk("add_alu", 64'(Alucontrol), 64'h2);
        ns = 0;
        while (Busy && ns < 100) begin tick(); ns++; end
        chk("add_divu_tail", 64'(ns), 64'd27);
        Funct = F_MFLO;
        #1 chk("add_divu_lo", 64'(HiLoOut), 64'd142);

        // mthi / mtlo then read next cycle
        Funct = F_MTHI; SrcA = 32'h1234;
        tick();
        Funct = F_MFHI; SrcA = '0;
        #1 chk("mthi_mfhi", 64'(HiLoOut), 64'h1234);
        Funct = F_MTLO; SrcA = 32'h5678;
        tick();
        Funct = F_MFLO;
        #1 chk("mtlo_mflo", 64'(HiLoOut), 64'h5678);

        // Reset in the middle of a div
        Funct = F_DIV; SrcA = 32'd100; SrcB = 32'd7;
        tick();
        Funct = F_MFLO;
        repeat (10) tick();
        chk("rstmid_busy_before", 64'(Busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_busy", 64'(Busy), 64'd0);
        chk("rstmid_stall", 64'(Stall), 64'd0);
        chk("rstmid_lo", 64'(HiLoOut), 64'd0);
        Funct = F_MFHI;
        #1 chk("rstmid_hi", 64'(HiLoOut), 64'd0);
        tick();
        reset = 1'b0;
        Funct = F_MFLO;
        tick();
        chk("rstrel_lo", 64'(HiLoOut), 64'd0);
        chk("rstrel_stall", 64'(Stall), 64'd0);
        chk("rstrel_busy", 64'(Busy), 64'd0);

        // Randomized mul/div against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = F_MULT + 6'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(f, a, b, hi, lo, n, ns);
            e = model(f, a, b);
            chk($sformatf("rnd%0d f=%b a=%h b=%h", k, f, a, b), {hi, lo}, e);
            chk($sformatf("rnd%0d_len", k), 64'(n), 64'd32);
            chk($sformatf("rnd%0d_stall", k), 64'(ns), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
